// File: rtl/life_gen_sched.sv
// life_gen_sched: double-buffered Game of Life sequencer, one cell per clock, LIFE_TORUS_EN selects toroidal wrap.
// start->done takes G*(ROWS*COLS+1)+1 clocks; no backpressure, start/wr_en/gens are ignored while busy.
module life_gen_sched #(
  parameter  int COLS = 8,
  parameter  int ROWS = 8,
  localparam int RW   = $clog2(ROWS),
  localparam int CW   = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      gens,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic [RW-1:0]   rd_row,
  output logic [COLS-1:0] rd_data,
  output logic            busy,
  output logic            done,
  output logic [7:0]      gen_count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SWAP, S_DONE} state_t;

  state_t          r_state;
  logic [COLS-1:0] r_cur [ROWS];
  logic [COLS-1:0] r_nxt [ROWS];
  logic [RW-1:0]   r_r;
  logic [CW-1:0]   r_c;
  logic [7:0]      r_rem;
  logic [7:0]      r_gen;
  logic            r_busy;
  logic            r_done;
  logic [COLS-1:0] r_rd;

  logic [RW-1:0]   w_rup, w_rdn;
  logic [CW-1:0]   w_cl, w_cr;
  logic            w_up_ok, w_dn_ok, w_lf_ok, w_rt_ok;
  logic [COLS-1:0] w_up, w_md, w_dn;
  logic [3:0]      w_n;
  logic            w_next;

  // Neighbour count for the cell under the scan pointer, read from cur only.
  always_comb begin
    w_rup = (r_r == '0) ? RW'(ROWS-1) : r_r - RW'(1);
    w_rdn = (r_r == RW'(ROWS-1)) ? '0 : r_r + RW'(1);
    w_cl  = (r_c == '0) ? CW'(COLS-1) : r_c - CW'(1);
    w_cr  = (r_c == CW'(COLS-1)) ? '0 : r_c + CW'(1);
`ifdef LIFE_TORUS_EN
    w_up_ok = 1'b1;
    w_dn_ok = 1'b1;
    w_lf_ok = 1'b1;
    w_rt_ok = 1'b1;
`else
    w_up_ok = (r_r != '0);
    w_dn_ok = (r_r != RW'(ROWS-1));
    w_lf_ok = (r_c != '0);
    w_rt_ok = (r_c != CW'(COLS-1));
`endif
    w_up = w_up_ok ? r_cur[w_rup] : '0;
    w_md = r_cur[r_r];
    w_dn = w_dn_ok ? r_cur[w_rdn] : '0;
    w_n  = 4'(w_up[w_cl] & w_lf_ok) + 4'(w_up[r_c]) + 4'(w_up[w_cr] & w_rt_ok)
         + 4'(w_md[w_cl] & w_lf_ok)                 + 4'(w_md[w_cr] & w_rt_ok)
         + 4'(w_dn[w_cl] & w_lf_ok) + 4'(w_dn[r_c]) + 4'(w_dn[w_cr] & w_rt_ok);
    w_next = (w_n == 4'd3) | (w_md[r_c] & (w_n == 4'd2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      for (int i = 0; i < ROWS; i++) begin
        r_cur[i] <= '0;
        r_nxt[i] <= '0;
      end
      r_r    <= '0;
      r_c    <= '0;
      r_rem  <= '0;
      r_gen  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_rd   <= '0;
    end else begin
      r_done <= 1'b0;
      r_rd   <= r_cur[rd_row];
      case (r_state)
        S_IDLE: begin
          // A write in the same cycle as start lands before the first scan reads cur.
          if (wr_en) r_cur[wr_row] <= wr_data;
          if (start) begin
            r_gen <= '0;
            if (gens != 8'd0) begin
              r_rem   <= gens;
              r_r     <= '0;
              r_c     <= '0;
              r_busy  <= 1'b1;
              r_state <= S_SCAN;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_SCAN: begin
          r_nxt[r_r][r_c] <= w_next;
          if (r_c == CW'(COLS-1)) begin
            r_c <= '0;
            if (r_r == RW'(ROWS-1)) begin
              r_r     <= '0;
              r_state <= S_SWAP;
            end else begin
              r_r <= r_r + RW'(1);
            end
          end else begin
            r_c <= r_c + CW'(1);
          end
        end
        S_SWAP: begin
          for (int i = 0; i < ROWS; i++) r_cur[i] <= r_nxt[i];
          if (r_gen != 8'hFF) r_gen <= r_gen + 8'd1;
          r_rem <= r_rem - 8'd1;
          if (r_rem == 8'd1) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_r     <= '0;
            r_c     <= '0;
            r_state <= S_SCAN;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data   = r_rd;
  assign busy      = r_busy;
  assign done      = r_done;
  assign gen_count = r_gen;

endmodule

// File: tb/tb_life_gen_sched.sv
// Bench for life_gen_sched: directed and random grids checked against a plain-array Life model.
module tb_life_gen_sched;
  localparam int COLS  = 8;
  localparam int ROWS  = 8;
  localparam int RW    = 3;
  localparam int CELLS = ROWS * COLS;
`ifdef LIFE_TORUS_EN
  localparam bit TORUS = 1'b1;
`else
  localparam bit TORUS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      gens = '0;
  logic            wr_en = 1'b0;
  logic [RW-1:0]   wr_row = '0;
  logic [COLS-1:0] wr_data = '0;
  logic [RW-1:0]   rd_row = '0;
  logic [COLS-1:0] rd_data;
  logic            busy;
  logic            done;
  logic [7:0]      gen_count;

  int checks = 0;
  int errors = 0;
  logic [COLS-1:0] m_cur [ROWS];
  int m_gen = 0;

  life_gen_sched #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gens(gens),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .rd_row(rd_row), .rd_data(rd_data),
    .busy(busy), .done(done), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One generation by the textbook rule, straight from the 2-D grid.
  task automatic m_step();
    logic [COLS-1:0] nx [ROWS];
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (TORUS) begin
              rr = (rr + ROWS) % ROWS;
              cc = (cc + COLS) % COLS;
            end
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
              n += int'(m_cur[rr][cc]);
          end
        end
        nx[r][c] = (n == 3) || (m_cur[r][c] && n == 2);
      end
    end
    m_cur = nx;
    m_gen = (m_gen == 255) ? 255 : m_gen + 1;
  endtask

  task automatic load_row(input int r, input logic [COLS-1:0] d);
    wr_en = 1'b1;
    wr_row = RW'(r);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    m_cur[r] = d;
  endtask

  task automatic clear_grid();
    for (int r = 0; r < ROWS; r++) load_row(r, '0);
  endtask

  task automatic check_grid(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      rd_row = RW'(r);
      tick();
      check($sformatf("%s row%0d", tag, r), 32'(rd_data), 32'(m_cur[r]));
    end
  endtask

  task automatic read_row(input int r);
    rd_row = RW'(r);
    tick();
  endtask

  // Runs g generations; inj>0 pulses a foreign write and start at that cycle.
  task automatic run(input string tag, input int g, input int inj, input bit do_wr,
                     input int wrow, input logic [COLS-1:0] wdat);
    int exp_done, done_first, done_cnt, busy_fall, busy_hi, both;
    start = 1'b1;
    gens = 8'(g);
    wr_en = do_wr;
    wr_row = RW'(wrow);
    wr_data = wdat;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    if (do_wr) m_cur[wrow] = wdat;
    m_gen = 0;
    for (int k = 0; k < g; k++) m_step();
    exp_done = g * (CELLS + 1) + 1;
    check($sformatf("%s busy@0", tag), 32'(busy), 32'(g > 0));
    done_first = -1;
    done_cnt = 0;
    busy_fall = -1;
    busy_hi = 0;
    both = 0;
    for (int e = 1; e <= exp_done + 3; e++) begin
      if (e == inj) begin
        start = 1'b1;
        gens = 8'd3;
        wr_en = 1'b1;
        wr_row = RW'(5);
        wr_data = 8'hFF;
      end
      tick();
      if (e == inj) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_first < 0) done_first = e;
      end
      if (busy) busy_hi++;
      else if (busy_fall < 0) busy_fall = e;
      if (busy && done) both++;
    end
    check($sformatf("%s done edge", tag), 32'(done_first), 32'(exp_done));
    check($sformatf("%s done pulses", tag), 32'(done_cnt), 32'd1);
    check($sformatf("%s busy fall", tag), 32'(busy_fall), 32'((g > 0) ? g * (CELLS + 1) : 1));
    check($sformatf("%s busy cycles", tag), 32'(busy_hi), 32'((g > 0) ? g * (CELLS + 1) - 1 : 0));
    check($sformatf("%s busy&done", tag), 32'(both), 32'd0);
    check($sformatf("%s gen_count", tag), 32'(gen_count), 32'(m_gen));
    check_grid(tag);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) m_cur[r] = '0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("reset rd_data", 32'(rd_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset gen_count", 32'(gen_count), 32'd0);
    rst_n = 1'b1;
    tick();
    check_grid("post reset");

    // Vertical blinker flips to horizontal
    load_row(2, 8'h08);
    load_row(3, 8'h08);
    load_row(4, 8'h08);
    run("blinker", 1, -1, 1'b0, 0, '0);
    read_row(3);
    check("blinker row3", 32'(rd_data), 32'h1C);

    // Block still life across five generations
    clear_grid();
    load_row(1, 8'h06);
    load_row(2, 8'h06);
    run("block", 5, -1, 1'b0, 0, '0);
    read_row(1);
    check("block row1", 32'(rd_data), 32'h06);

    // Blinker on the top edge
    clear_grid();
    load_row(0, 8'h07);
    run("edge", 1, -1, 1'b0, 0, '0);
    read_row(0);
    check("edge row0", 32'(rd_data), 32'h02);
    read_row(1);
    check("edge row1", 32'(rd_data), 32'h02);
    read_row(7);
    check("edge row7", 32'(rd_data), TORUS ? 32'h02 : 32'h00);

    // Zero generations: immediate done, grid kept, counter cleared
    run("gens0", 0, -1, 1'b0, 0, '0);

    // Write then readback latency
    rd_row = RW'(6);
    wr_en = 1'b1;
    wr_row = RW'(6);
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    check("wr lat 1 edge", 32'(rd_data), 32'(m_cur[6]));
    tick();
    check("wr lat 2 edge", 32'(rd_data), 32'hA5);
    m_cur[6] = 8'hA5;

    // Foreign write and start mid-scan must be ignored
    clear_grid();
    load_row(2, 8'h08);
    load_row(3, 8'h08);
    load_row(4, 8'h08);
    run("ignore", 2, 20, 1'b0, 0, '0);

    // Write coincident with start seeds the run
    clear_grid();
    run("wr+start", 1, -1, 1'b1, 3, 8'h1C);

    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < ROWS; r++) load_row(r, 8'($urandom));
      run($sformatf("rand%0d", it), int'($urandom_range(1, 3)), -1, 1'b0, 0, '0);
    end

    // Reset in the middle of a run
    clear_grid();
    load_row(2, 8'h08);
    load_row(3, 8'h08);
    load_row(4, 8'h08);
    rd_row = RW'(3);
    start = 1'b1;
    gens = 8'd1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    check("midrun busy", 32'(busy), 32'd1);
    check("midrun rd_data", 32'(rd_data), 32'h08);
    rst_n = 1'b0;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst done", 32'(done), 32'd0);
    check("arst gen_count", 32'(gen_count), 32'd0);
    check("arst rd_data", 32'(rd_data), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < ROWS; r++) m_cur[r] = '0;
    tick();
    check("post arst done", 32'(done), 32'd0);
    check_grid("post arst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
